// File: rtl/if_fetch_pkg.sv
// Shared widths, defaults and the buffered-instruction record for the fetch stage.
package if_fetch_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int FIFO_DEPTH  = 2;

  localparam logic [PC_WIDTH-1:0]    RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^PC_WIDTH.
  function automatic logic [PC_WIDTH-1:0] pc_next(input logic [PC_WIDTH-1:0] pc);
    return pc + PC_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO used both for fetched {pc, instr} pairs and for the PC tag queue.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_cnt;
  logic             w_pop;

  assign w_pop   = i_pop & (r_cnt != 2'd0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_cnt == 2'(FIFO_DEPTH));
  assign o_empty = (r_cnt == 2'd0);
  assign o_cnt   = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst | i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push & ~i_flush) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: credit-limited in-order bus requests, PC-tagged response buffer,
// stall hold and jump redirect with discard of in-flight responses.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   jump_i,
  input  logic [PC_WIDTH-1:0]    jump_addr_i,
  output logic                   ibus_req_o,
  output logic [PC_WIDTH-1:0]    ibus_addr_o,
  input  logic                   ibus_gnt_i,
  input  logic                   ibus_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] ibus_rdata_i,
  output logic [PC_WIDTH-1:0]    if_pc_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o,
  output logic                   if_valid_o
);

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [1:0]          r_out_cnt;
  logic [1:0]          r_drop_cnt;

  logic                w_pop;
  logic                w_push;
  logic                w_issue;
  logic                w_drop;
  logic [2:0]          w_credit;
  logic [1:0]          w_fifo_cnt;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  fetch_entry_t        w_head;
  fetch_entry_t        w_push_entry;
  logic [PC_WIDTH-1:0] w_tag_head;
  logic [1:0]          w_tag_cnt;
  logic                w_tag_full;
  logic                w_tag_empty;

  assign w_pop    = ~w_fifo_empty & ~stall_i & ~jump_i;
  // Outstanding plus buffered after this cycle's pop must leave a slot for every response.
  assign w_credit = {1'b0, r_out_cnt} + {1'b0, w_fifo_cnt} - {2'b00, w_pop};
  assign ibus_req_o = ~rst & ~jump_i & (w_credit < 3'd2);
  assign w_issue  = ibus_req_o & ibus_gnt_i;
  assign w_drop   = (r_drop_cnt != 2'd0);
  assign w_push   = ibus_rvalid_i & ~w_drop & ~jump_i;
  assign w_push_entry = '{pc: w_tag_head, instr: ibus_rdata_i};

  fetch_fifo #(.WIDTH($bits(fetch_entry_t))) u_instr_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (jump_i),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_cnt   (w_fifo_cnt)
  );

  // Tags survive a redirect so dropped responses still retire their own entry.
  fetch_fifo #(.WIDTH(PC_WIDTH)) u_tag_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_issue),
    .i_pop   (ibus_rvalid_i),
    .i_flush (1'b0),
    .i_data  (r_fetch_pc),
    .o_head  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_cnt   (w_tag_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_out_cnt  <= 2'd0;
      r_drop_cnt <= 2'd0;
    end else if (jump_i) begin
      r_fetch_pc <= jump_addr_i;
      r_out_cnt  <= r_out_cnt - {1'b0, ibus_rvalid_i};
      r_drop_cnt <= r_out_cnt - {1'b0, ibus_rvalid_i};
    end else begin
      if (w_issue) r_fetch_pc <= pc_next(r_fetch_pc);
      r_out_cnt <= r_out_cnt + {1'b0, w_issue} - {1'b0, ibus_rvalid_i};
      if (ibus_rvalid_i & w_drop) r_drop_cnt <= r_drop_cnt - 2'd1;
    end
  end

  always_comb begin
    ibus_addr_o = r_fetch_pc;
    if_valid_o  = 1'b0;
    if_pc_o     = r_fetch_pc;
    if_instr_o  = NOP_INSTR;
    if (rst) begin
      ibus_addr_o = RESET_PC;
      if_pc_o     = RESET_PC;
    end else if (~w_fifo_empty) begin
      if_valid_o = 1'b1;
      if_pc_o    = w_head.pc;
      if_instr_o = w_head.instr;
    end
  end

  a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
    ibus_rvalid_i |-> (r_out_cnt != 2'd0));
  a_fifo_room: assert property (@(posedge clk) disable iff (rst)
    w_push |-> (~w_fifo_full | w_pop));
  a_tag_room: assert property (@(posedge clk) disable iff (rst)
    w_issue |-> (~w_tag_full | ibus_rvalid_i));
  a_tag_tracks_out: assert property (@(posedge clk) disable iff (rst)
    (w_tag_cnt == r_out_cnt) && (w_tag_empty == (r_out_cnt == 2'd0)));

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vector table plus a hand-driven redirect sequence.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        jump_i;
  logic [31:0] jump_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .jump_i        (jump_i),
    .jump_addr_i   (jump_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_valid_o    (if_valid_o)
  );

  typedef struct {
    logic        rst, stall, jump;
    logic [31:0] jaddr;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc, einstr;
  } vec_t;

  vec_t vecs[$];

  // Memory image seen by the bus model: each word is tagged with its own address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return 32'h5A00_0000 ^ a;
  endfunction

  task automatic add(input logic rs, st, jp, input logic [31:0] ja,
                     input logic g, rv, input logic [31:0] ra,
                     input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ep);
    vec_t v;
    v.rst = rs; v.stall = st; v.jump = jp; v.jaddr = ja;
    v.gnt = g; v.rvalid = rv; v.rdata = rv ? instr_of(ra) : 32'h0;
    v.ereq = er; v.eaddr = ea; v.evalid = ev; v.epc = ep;
    v.einstr = ev ? instr_of(ep) : NOP;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rs, st, jp, input logic [31:0] ja,
                       input logic g, rv, input logic [31:0] rd);
    @(negedge clk);
    rst = rs; stall_i = st; jump_i = jp; jump_addr_i = ja;
    ibus_gnt_i = g; ibus_rvalid_i = rv; ibus_rdata_i = rd;
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic        pend, npend, found;
  logic [31:0] paddr, naddr;

  initial begin
    rst = 1'b1; stall_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;

    //  rst st jp jaddr          g rv raddr          req addr           vld pc
    add(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          0, 32'h0);
    add(1, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          0, 32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,          0, 32'h0);
    add(0, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h4,          0, 32'h4);
    add(0, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h8,          1, 32'h0);
    add(0, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'hC,          1, 32'h4);
    add(0, 1, 0, 32'h0,         1, 1, 32'hC,         0, 32'h10,         1, 32'h8);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,         1, 32'h8);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h10,         1, 32'h8);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10,         1, 32'h8);
    add(0, 0, 0, 32'h0,         1, 1, 32'h10,        1, 32'h14,         1, 32'hC);
    add(0, 0, 0, 32'h0,         1, 1, 32'h14,        1, 32'h18,         1, 32'h10);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h1C,         1, 32'h14);
    add(0, 0, 1, 32'h100,       1, 0, 32'h0,         0, 32'h20,         0, 32'h20);
    add(0, 0, 0, 32'h0,         1, 1, 32'h18,        0, 32'h100,        0, 32'h100);
    add(0, 0, 0, 32'h0,         1, 1, 32'h1C,        1, 32'h100,        0, 32'h100);
    add(0, 0, 0, 32'h0,         1, 1, 32'h100,       1, 32'h104,        0, 32'h104);
    add(0, 0, 0, 32'h0,         1, 1, 32'h104,       1, 32'h108,        1, 32'h100);
    add(0, 0, 0, 32'h0,         1, 1, 32'h108,       1, 32'h10C,        1, 32'h104);
    add(0, 1, 0, 32'h0,         1, 1, 32'h10C,       0, 32'h110,        1, 32'h108);
    add(0, 1, 1, 32'h200,       1, 0, 32'h0,         0, 32'h110,        1, 32'h108);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,        0, 32'h200);
    add(0, 0, 0, 32'h0,         1, 1, 32'h200,       1, 32'h204,        0, 32'h204);
    add(0, 0, 0, 32'h0,         1, 1, 32'h204,       1, 32'h208,        1, 32'h200);
    add(0, 0, 0, 32'h0,         1, 1, 32'h208,       1, 32'h20C,        1, 32'h204);
    add(0, 0, 1, 32'hFFFF_FFF8, 1, 1, 32'h20C,       0, 32'h210,        1, 32'h208);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFF8,  0, 32'hFFFF_FFF8);
    add(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC);
    add(0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 32'h0,          1, 32'hFFFF_FFF8);
    add(0, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h4,          1, 32'hFFFF_FFFC);
    add(0, 1, 0, 32'h0,         1, 1, 32'h4,         0, 32'h8,          1, 32'h0);
    add(1, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,          0, 32'h0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,          0, 32'h0);
    add(0, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'h4,          0, 32'h4);
    add(0, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h8,          1, 32'h0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h8,         1, 32'hC,          1, 32'h4);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,          1, 32'h8);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,          0, 32'hC);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].jump, vecs[i].jaddr,
            vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      n_tests++;
      if (ibus_req_o !== vecs[i].ereq || ibus_addr_o !== vecs[i].eaddr ||
          if_valid_o !== vecs[i].evalid || if_pc_o !== vecs[i].epc ||
          if_instr_o !== vecs[i].einstr) begin
        n_fail++;
        $display("FAIL vec%0d: got req=%0b addr=%h valid=%0b pc=%h instr=%h, expected req=%0b addr=%h valid=%0b pc=%h instr=%h",
                 i, ibus_req_o, ibus_addr_o, if_valid_o, if_pc_o, if_instr_o,
                 vecs[i].ereq, vecs[i].eaddr, vecs[i].evalid, vecs[i].epc, vecs[i].einstr);
      end
    end

    // Held redirect: no request while jump_i is high, target visible once loaded.
    drive(0, 0, 1, 32'h40, 1, 0, 32'h0);
    check_val("jump_hold_req0_a", {31'b0, ibus_req_o}, 32'h0);
    drive(0, 0, 1, 32'h40, 1, 0, 32'h0);
    check_val("jump_hold_req0_b", {31'b0, ibus_req_o}, 32'h0);
    check_val("jump_hold_addr", ibus_addr_o, 32'h40);

    // Free-running bus model with one-cycle response; bounded wait for the first real instruction.
    pend = 1'b0; paddr = '0; found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      drive(0, 0, 0, 32'h0, 1, pend, pend ? instr_of(paddr) : 32'h0);
      npend = ibus_req_o & ibus_gnt_i;
      naddr = ibus_addr_o;
      if (if_valid_o === 1'b1) found = 1'b1;
      pend = npend; paddr = naddr;
    end
    if (!found) begin
      n_tests++; n_fail++;
      $display("FAIL redirect_timeout: got no valid instruction in 8 cycles, expected pc %h", 32'h40);
    end else begin
      check_val("redirect_first_pc", if_pc_o, 32'h40);
      check_val("redirect_first_instr", if_instr_o, instr_of(32'h40));
      drive(0, 0, 0, 32'h0, 1, pend, pend ? instr_of(paddr) : 32'h0);
      check_val("redirect_second_valid", {31'b0, if_valid_o}, 32'h1);
      check_val("redirect_second_pc", if_pc_o, 32'h44);
    end

    drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
    check_val("final_reset_valid", {31'b0, if_valid_o}, 32'h0);
    check_val("final_reset_instr", if_instr_o, NOP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
